// File: rtl/ts_pack_buf_sched.sv
// Scheduler in front of the 10-bit-in / 32-bit-packed TS buffer: arbitrates one writer
// and one reader, tracks occupancy in words and emits registered, spaced strobes.
module ts_pack_buf_sched #(
  parameter int DEPTH  = 35,
  parameter int HI_WM  = 28,
  parameter int LO_WM  = 4,
  parameter int RD_LAT = 1
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       WR_REQ,
  input  logic [9:0] WR_DATA,
  output logic       WR_ACK,
  input  logic       RD_REQ,
  output logic [9:0] RD_DATA,
  output logic       RD_VALID,
  input  logic       FLUSH,
  output logic       BUF_WRITE,
  output logic       BUF_READ,
  output logic       BUF_CLR,
  output logic [9:0] BUF_DATA_IN,
  input  logic [9:0] BUF_DATA_OUT,
  output logic [5:0] FILL,
  output logic       FULL,
  output logic       EMPTY
);

  if (DEPTH < 1 || DEPTH > 63) begin : g_bad_depth
    $error("ts_pack_buf_sched: DEPTH must be 1..63 to fit the 6-bit FILL");
  end
  if (RD_LAT < 1 || RD_LAT > 7) begin : g_bad_lat
    $error("ts_pack_buf_sched: RD_LAT must be 1..7");
  end

  localparam logic [5:0] DEPTH_W = 6'(DEPTH);
  localparam logic [5:0] HI_W    = 6'(HI_WM);
  localparam logic [5:0] LO_W    = 6'(LO_WM);

  typedef enum logic [2:0] {IDLE, WSET, WSTB, RSTB, RWAIT, GAP} state_t;

  state_t            state, state_nxt;
  logic              last_rd, last_rd_nxt;     // 1: previous grant was a read
  logic [RD_LAT:0]   vld_pipe, vld_pipe_nxt;   // bit k: k cycles after the read strobe
  logic [5:0]        fill_nxt;
  logic [9:0]        rd_data_nxt, buf_data_in_nxt;
  logic              wr_ack_nxt, rd_valid_nxt, buf_write_nxt, buf_read_nxt;
  logic              wr_ok, rd_ok, pick_rd;

  always_comb begin
    wr_ok = WR_REQ & ~FULL;
    rd_ok = RD_REQ & ~EMPTY;
    if (wr_ok && rd_ok) begin
      if (FILL >= HI_W)      pick_rd = 1'b1;
      else if (FILL <= LO_W) pick_rd = 1'b0;
      else                   pick_rd = ~last_rd;
    end else begin
      pick_rd = rd_ok;
    end
  end

  // Every output is computed one cycle early and registered, so strobes line up with states.
  always_comb begin
    state_nxt       = state;
    last_rd_nxt     = last_rd;
    fill_nxt        = FILL;
    rd_data_nxt     = RD_DATA;
    buf_data_in_nxt = BUF_DATA_IN;
    wr_ack_nxt      = 1'b0;
    rd_valid_nxt    = 1'b0;
    buf_write_nxt   = 1'b0;
    buf_read_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ok || rd_ok) begin
          if (pick_rd) begin
            state_nxt    = RSTB;
            buf_read_nxt = 1'b1;
            fill_nxt     = FILL - 6'd1;
            last_rd_nxt  = 1'b1;
          end else begin
            state_nxt       = WSET;
            buf_data_in_nxt = WR_DATA;
          end
        end
      end
      WSET: begin
        state_nxt     = WSTB;
        buf_write_nxt = 1'b1;
        wr_ack_nxt    = 1'b1;
        fill_nxt      = FILL + 6'd1;
        last_rd_nxt   = 1'b0;
      end
      WSTB:  state_nxt = GAP;
      RSTB:  state_nxt = RWAIT;
      RWAIT: begin
        if (vld_pipe[RD_LAT]) begin
          state_nxt    = GAP;
          rd_valid_nxt = 1'b1;
          rd_data_nxt  = BUF_DATA_OUT;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    vld_pipe_nxt = {vld_pipe[RD_LAT-1:0], buf_read_nxt};

    // Flush wins over any transition; BUF_DATA_IN and last_rd keep their values.
    if (FLUSH) begin
      state_nxt       = IDLE;
      last_rd_nxt     = last_rd;
      fill_nxt        = 6'd0;
      rd_data_nxt     = RD_DATA;
      buf_data_in_nxt = BUF_DATA_IN;
      wr_ack_nxt      = 1'b0;
      rd_valid_nxt    = 1'b0;
      buf_write_nxt   = 1'b0;
      buf_read_nxt    = 1'b0;
      vld_pipe_nxt    = '0;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      last_rd     <= 1'b1;
      vld_pipe    <= '0;
      FILL        <= 6'd0;
      FULL        <= 1'b0;
      EMPTY       <= 1'b1;
      RD_DATA     <= 10'd0;
      BUF_DATA_IN <= 10'd0;
      WR_ACK      <= 1'b0;
      RD_VALID    <= 1'b0;
      BUF_WRITE   <= 1'b0;
      BUF_READ    <= 1'b0;
      BUF_CLR     <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_rd     <= last_rd_nxt;
      vld_pipe    <= vld_pipe_nxt;
      FILL        <= fill_nxt;
      FULL        <= (fill_nxt == DEPTH_W);
      EMPTY       <= (fill_nxt == 6'd0);
      RD_DATA     <= rd_data_nxt;
      BUF_DATA_IN <= buf_data_in_nxt;
      WR_ACK      <= wr_ack_nxt;
      RD_VALID    <= rd_valid_nxt;
      BUF_WRITE   <= buf_write_nxt;
      BUF_READ    <= buf_read_nxt;
      BUF_CLR     <= FLUSH;
    end
  end

endmodule

// File: tb/tb_ts_pack_buf_sched.sv
// Bench for ts_pack_buf_sched: behavioural buffer, write/read scoreboards, strobe
// spacing monitor and one task per scenario.
module tb_ts_pack_buf_sched;
  localparam int DEPTH = 35;
  localparam int HI_WM = 28;
  localparam int LO_WM = 4;

  logic       CLOCK = 1'b0, RESET = 1'b1;
  logic       WR_REQ = 1'b0, RD_REQ = 1'b0, FLUSH = 1'b0;
  logic [9:0] WR_DATA = 10'd0, BUF_DATA_OUT = 10'd0;
  logic       WR_ACK, RD_VALID, BUF_WRITE, BUF_READ, BUF_CLR, FULL, EMPTY;
  logic [9:0] RD_DATA, BUF_DATA_IN;
  logic [5:0] FILL;

  int ncmp = 0, nfail = 0;
  int nbw = 0, nbr = 0, nack = 0, nvld = 0;
  logic [9:0] wr_q[$];
  logic [9:0] rd_q[$];
  logic [9:0] mem [0:DEPTH-1];
  int wp = 0, rp = 0;

  ts_pack_buf_sched #(.DEPTH(DEPTH), .HI_WM(HI_WM), .LO_WM(LO_WM), .RD_LAT(1)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .WR_REQ(WR_REQ), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
    .RD_REQ(RD_REQ), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .FLUSH(FLUSH),
    .BUF_WRITE(BUF_WRITE), .BUF_READ(BUF_READ), .BUF_CLR(BUF_CLR),
    .BUF_DATA_IN(BUF_DATA_IN), .BUF_DATA_OUT(BUF_DATA_OUT),
    .FILL(FILL), .FULL(FULL), .EMPTY(EMPTY));

  always #5 CLOCK = ~CLOCK;

  // Behavioural buffer: data appears one cycle after the read strobe.
  always @(posedge CLOCK) begin
    if (RESET || BUF_CLR) begin
      wp <= 0;
      rp <= 0;
    end else begin
      if (BUF_WRITE) begin
        mem[wp] <= BUF_DATA_IN;
        wp <= (wp + 1) % DEPTH;
      end
      if (BUF_READ) begin
        BUF_DATA_OUT <= mem[rp];
        rp <= (rp + 1) % DEPTH;
      end
    end
  end

  initial begin : mon
    logic pw, pr, pc, pa, pv;
    logic [9:0] e;
    pw = 0; pr = 0; pc = 0; pa = 0; pv = 0;
    forever begin
      @(negedge CLOCK);
      if (RESET) begin
        pw = 0; pr = 0; pc = 0; pa = 0; pv = 0;
      end else begin
        ncmp++;
        if (((pw || pr) && (BUF_WRITE || BUF_READ)) || (pc && BUF_CLR) || (pa && WR_ACK) ||
            (pv && RD_VALID) || (int'(FILL) > DEPTH)) begin
          nfail++;
          $display("FAIL strobe_rule t=%0t: prev w/r/clr/ack/vld=%b%b%b%b%b now=%b%b%b%b%b fill=%0d (need single-cycle spaced strobes, fill<=%0d)",
                   $time, pw, pr, pc, pa, pv, BUF_WRITE, BUF_READ, BUF_CLR, WR_ACK, RD_VALID, FILL, DEPTH);
        end
        if (BUF_WRITE) begin
          nbw++;
          ncmp++;
          if (wr_q.size() == 0) begin
            nfail++;
            $display("FAIL wr_sb t=%0t: unexpected BUF_WRITE data %h", $time, BUF_DATA_IN);
          end else begin
            e = wr_q.pop_front();
            if (BUF_DATA_IN !== e) begin
              nfail++;
              $display("FAIL wr_sb t=%0t: BUF_DATA_IN %h expected %h", $time, BUF_DATA_IN, e);
            end
          end
        end
        if (BUF_READ) nbr++;
        if (WR_ACK) nack++;
        if (RD_VALID) begin
          nvld++;
          ncmp++;
          if (rd_q.size() == 0) begin
            nfail++;
            $display("FAIL rd_sb t=%0t: unexpected RD_VALID data %h", $time, RD_DATA);
          end else begin
            e = rd_q.pop_front();
            if (RD_DATA !== e) begin
              nfail++;
              $display("FAIL rd_sb t=%0t: RD_DATA %h expected %h", $time, RD_DATA, e);
            end
          end
        end
        pw = BUF_WRITE; pr = BUF_READ; pc = BUF_CLR; pa = WR_ACK; pv = RD_VALID;
      end
    end
  end

  task automatic apply_reset();
    RESET = 1; WR_REQ = 0; RD_REQ = 0; FLUSH = 0;
    repeat (4) @(negedge CLOCK);
    wr_q.delete();
    rd_q.delete();
    RESET = 0;
  endtask

  task automatic wr(input logic [9:0] d);
    int t;
    WR_DATA = d; WR_REQ = 1;
    wr_q.push_back(d);
    rd_q.push_back(d);
    t = 0;
    do begin @(negedge CLOCK); t++; end while (!WR_ACK && t < 40);
    ncmp++;
    if (!WR_ACK) begin
      nfail++;
      $display("FAIL wr_timeout: no WR_ACK after %0d cycles for %h, want ack", t, d);
    end
    WR_REQ = 0;
  endtask

  task automatic rd();
    int t;
    RD_REQ = 1;
    t = 0;
    do begin @(negedge CLOCK); t++; end while (!RD_VALID && t < 40);
    ncmp++;
    if (!RD_VALID) begin
      nfail++;
      $display("FAIL rd_timeout: no RD_VALID after %0d cycles, want valid", t);
    end
    RD_REQ = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    #40;
    ncmp++;
    if ({WR_ACK, RD_VALID, BUF_WRITE, BUF_READ, BUF_CLR, FULL} !== 6'b0) begin
      nfail++;
      $display("FAIL reset_strobes: ack/vld/w/r/clr/full=%b want 000000",
               {WR_ACK, RD_VALID, BUF_WRITE, BUF_READ, BUF_CLR, FULL});
    end
    ncmp++;
    if (EMPTY !== 1'b1 || FILL !== 6'd0) begin
      nfail++;
      $display("FAIL reset_fill: EMPTY=%b FILL=%0d want 1/0", EMPTY, FILL);
    end
    ncmp++;
    if (RD_DATA !== 10'd0 || BUF_DATA_IN !== 10'd0) begin
      nfail++;
      $display("FAIL reset_data: RD_DATA=%h BUF_DATA_IN=%h want 0/0", RD_DATA, BUF_DATA_IN);
    end
    @(negedge CLOCK);
    RESET = 0;
  endtask

  task automatic test_write11();
    int b0;
    logic [9:0] base;
    base = 10'h200;
    b0 = nbw;
    for (int i = 0; i < 11; i++) wr(base >> i);
    @(negedge CLOCK);
    ncmp++;
    if (nbw - b0 != 11) begin
      nfail++;
      $display("FAIL w11_pulses: %0d BUF_WRITE pulses want 11", nbw - b0);
    end
    ncmp++;
    if (FILL !== 6'd11 || EMPTY !== 1'b0) begin
      nfail++;
      $display("FAIL w11_fill: FILL=%0d EMPTY=%b want 11/0", FILL, EMPTY);
    end
  endtask

  task automatic test_full();
    int b0, a0, t;
    logic [9:0] d;
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      wr(10'($urandom));
      if (i == DEPTH - 2) begin
        ncmp++;
        if (FULL !== 1'b0) begin
          nfail++;
          $display("FAIL full_early: FULL=%b at FILL=%0d want 0", FULL, FILL);
        end
      end
    end
    ncmp++;
    if (FULL !== 1'b1 || FILL !== 6'(DEPTH)) begin
      nfail++;
      $display("FAIL full_set: FULL=%b FILL=%0d want 1/%0d", FULL, FILL, DEPTH);
    end
    d = 10'($urandom);
    WR_DATA = d; WR_REQ = 1;
    wr_q.push_back(d);
    rd_q.push_back(d);
    b0 = nbw; a0 = nack;
    repeat (20) @(negedge CLOCK);
    ncmp++;
    if (nbw != b0 || nack != a0) begin
      nfail++;
      $display("FAIL full_stall: %0d writes %0d acks while full, want 0/0", nbw - b0, nack - a0);
    end
    rd();
    t = 0;
    do begin @(negedge CLOCK); t++; end while (!WR_ACK && t < 20);
    WR_REQ = 0;
    @(negedge CLOCK);
    ncmp++;
    if (nbw != b0 + 1 || FILL !== 6'(DEPTH) || FULL !== 1'b1) begin
      nfail++;
      $display("FAIL full_resume: writes=%0d FILL=%0d FULL=%b want 1/%0d/1", nbw - b0, FILL, FULL, DEPTH);
    end
  endtask

  task automatic test_drain();
    int r0, v0;
    apply_reset();
    for (int i = 0; i < 22; i++) wr(10'($urandom));
    for (int i = 0; i < 22; i++) rd();
    @(negedge CLOCK);
    ncmp++;
    if (FILL !== 6'd0 || EMPTY !== 1'b1 || rd_q.size() != 0) begin
      nfail++;
      $display("FAIL drain_end: FILL=%0d EMPTY=%b left=%0d want 0/1/0", FILL, EMPTY, rd_q.size());
    end
    r0 = nbr; v0 = nvld;
    RD_REQ = 1;
    repeat (20) @(negedge CLOCK);
    RD_REQ = 0;
    ncmp++;
    if (nbr != r0 || nvld != v0) begin
      nfail++;
      $display("FAIL empty_stall: %0d reads %0d valids while empty, want 0/0", nbr - r0, nvld - v0);
    end
  endtask

  task automatic test_priority(input int start, input int ngr);
    int fm, t;
    logic lm, er, gr;
    logic [9:0] d;
    apply_reset();
    for (int i = 0; i < start; i++) wr(10'($urandom));
    fm = start;
    lm = (start == 0);
    d = 10'($urandom);
    WR_DATA = d;
    wr_q.push_back(d);
    rd_q.push_back(d);
    WR_REQ = 1; RD_REQ = 1;
    for (int g = 0; g < ngr; g++) begin
      t = 0;
      do begin @(negedge CLOCK); t++; end while (!BUF_WRITE && !BUF_READ && t < 20);
      ncmp++;
      if (!BUF_WRITE && !BUF_READ) begin
        nfail++;
        $display("FAIL prio_timeout: no grant from FILL=%0d", fm);
        WR_REQ = 0; RD_REQ = 0;
        return;
      end
      er = (fm >= HI_WM) ? 1'b1 : (fm <= LO_WM) ? 1'b0 : ~lm;
      gr = BUF_READ;
      if (gr !== er) begin
        nfail++;
        $display("FAIL prio_grant: at fill %0d got %s want %s", fm, gr ? "R" : "W", er ? "R" : "W");
      end
      fm = gr ? fm - 1 : fm + 1;
      lm = gr;
      ncmp++;
      if (FILL !== 6'(fm)) begin
        nfail++;
        $display("FAIL prio_fill: FILL=%0d want %0d", FILL, fm);
      end
      if (!gr) begin
        if (g < ngr - 1) begin
          d = 10'($urandom);
          WR_DATA = d;
          wr_q.push_back(d);
          rd_q.push_back(d);
        end else begin
          WR_REQ = 0; RD_REQ = 0;
        end
      end else if (g == ngr - 1) begin
        WR_REQ = 0;
        void'(wr_q.pop_back());
        void'(rd_q.pop_back());
        t = 0;
        do begin @(negedge CLOCK); t++; end while (!RD_VALID && t < 20);
        RD_REQ = 0;
      end
    end
    repeat (4) @(negedge CLOCK);
  endtask

  task automatic test_flush();
    int t, v0;
    logic [9:0] keep;
    apply_reset();
    for (int i = 0; i < 13; i++) wr(10'($urandom));
    keep = rd_q[0];
    rd();
    RD_REQ = 1;
    t = 0;
    do begin @(negedge CLOCK); t++; end while (!BUF_READ && t < 20);
    @(negedge CLOCK);
    FLUSH = 1; RD_REQ = 0;
    rd_q.delete();
    v0 = nvld;
    @(negedge CLOCK);
    FLUSH = 0;
    ncmp++;
    if (BUF_CLR !== 1'b1 || FILL !== 6'd0 || EMPTY !== 1'b1 || RD_VALID !== 1'b0) begin
      nfail++;
      $display("FAIL flush_now: CLR=%b FILL=%0d EMPTY=%b VALID=%b want 1/0/1/0", BUF_CLR, FILL, EMPTY, RD_VALID);
    end
    ncmp++;
    if (RD_DATA !== keep) begin
      nfail++;
      $display("FAIL flush_rd_data: RD_DATA=%h want %h", RD_DATA, keep);
    end
    @(negedge CLOCK);
    ncmp++;
    if (BUF_CLR !== 1'b0) begin
      nfail++;
      $display("FAIL flush_clr_width: BUF_CLR=%b want 0", BUF_CLR);
    end
    repeat (5) @(negedge CLOCK);
    ncmp++;
    if (nvld != v0) begin
      nfail++;
      $display("FAIL flush_valid: %0d RD_VALID after flush want 0", nvld - v0);
    end
    wr(10'h155);
    ncmp++;
    if (FILL !== 6'd1) begin
      nfail++;
      $display("FAIL flush_after: FILL=%0d want 1", FILL);
    end
    rd();
  endtask

  task automatic test_async_reset();
    int a0, b0;
    logic hit;
    apply_reset();
    WR_DATA = 10'h2a5; WR_REQ = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge CLOCK);
      #1;
      hit = BUF_WRITE;
    end
    ncmp++;
    if (!hit) begin
      nfail++;
      $display("FAIL areset_setup: BUF_WRITE never rose, want 1");
    end
    #2 RESET = 1;
    #1;
    WR_REQ = 0;
    ncmp++;
    if (BUF_WRITE !== 1'b0 || WR_ACK !== 1'b0 || FILL !== 6'd0 || EMPTY !== 1'b1 || FULL !== 1'b0) begin
      nfail++;
      $display("FAIL areset_cut: W=%b ACK=%b FILL=%0d EMPTY=%b FULL=%b want 0/0/0/1/0",
               BUF_WRITE, WR_ACK, FILL, EMPTY, FULL);
    end
    @(negedge CLOCK);
    RESET = 0;
    a0 = nack; b0 = nbw;
    repeat (10) @(negedge CLOCK);
    ncmp++;
    if (nack != a0 || nbw != b0 || FILL !== 6'd0) begin
      nfail++;
      $display("FAIL areset_after: acks=%0d writes=%0d FILL=%0d want 0/0/0", nack - a0, nbw - b0, FILL);
    end
  endtask

  initial begin
    test_reset();
    test_write11();
    test_full();
    test_drain();
    test_priority(10, 8);
    test_priority(29, 8);
    test_priority(3, 8);
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
